pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: data bits per entry; legal range 1..64.
REQ-002 The block SHALL take parameter RESET_VAL, default 16'h0800 (NOP encoding): value driven on out_data whenever no entry is held.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: producer payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a live entry.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_data this cycle.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the oldest held entry, or RESET_VAL.

Function
REQ-012 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-013 The block SHALL implement a 3-state FSM: EMPTY (0 entries), ONE (main register live), TWO (main and skid registers live).
REQ-014 In EMPTY, in_fire SHALL load main and move to ONE; otherwise the FSM SHALL hold.
REQ-015 In ONE:
- in_fire & out_fire SHALL load main and stay in ONE.
- in_fire only SHALL load skid and move to TWO.
- out_fire only SHALL move to EMPTY.
- Otherwise the FSM SHALL hold.
REQ-016 In TWO, out_fire SHALL copy skid into main and move to ONE; otherwise the FSM SHALL hold.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 exactly when state is not EMPTY; out_data SHALL be main when out_valid=1, else RESET_VAL.
REQ-019 Latency SHALL be 1 cycle from in_fire to out_valid; sustained throughput SHALL be 1 entry/cycle when out_ready is held at 1.
REQ-020 Entries SHALL leave in strict acceptance order, with none dropped or duplicated.
REQ-021 When no fire occurs, main and skid SHALL hold their values; unused registers SHALL NOT be required to clear.
REQ-022 flush=1 SHALL force EMPTY at the next edge and discard any same-cycle in_fire; flush SHALL take priority over every other transition.
REQ-023 Changes to in_data while in_valid=1 and in_ready=0 SHALL have no effect.

Reset
REQ-024 rst=1 at a clock edge SHALL force EMPTY, main=RESET_VAL and skid=RESET_VAL, with rst taking priority over flush and the handshakes.
REQ-025 The reset values SHALL be in_ready=1, out_valid=0 and out_data=RESET_VAL, visible in the first cycle after the reset edge.
REQ-026 rst asserted mid-transfer SHALL discard all held entries, and no out_fire SHALL be reported for them.

Structure
REQ-027 A shared package SHALL hold the FSM state type (EMPTY/ONE/TWO, 2 bits) and the default WIDTH and RESET_VAL constants.
REQ-028 main and skid SHALL each be one instance of a single sub-module, reg_en_param: a WIDTH-bit register with enable, synchronous active-high reset to a parameter value, and ports clk and rst.
REQ-029 All next-state and load-select logic SHALL be in pipe_skid_reg, with no latches and no second clock.

Verification
REQ-030 Scenario: rst for 2 cycles, then release -> in_ready=1, out_valid=0 and out_data=16'h0800.
REQ-031 Scenario: out_ready=1 constant, in_data 16'h1111, 16'h2222, 16'h3333 on consecutive cycles -> out_data shows them in order, each 1 cycle later, with in_ready never 0.
REQ-032 Scenario: out_ready=0, offer 16'hAAAA then 16'hBBBB -> both accepted and in_ready=0 afterward; then out_ready=1 -> AAAA then BBBB on consecutive cycles, and in_ready returns to 1 one cycle after the first out_fire.
REQ-033 Scenario: TWO state, then flush=1 with in_valid=1 and in_data=16'hCCCC -> next cycle out_valid=0, out_data=16'h0800, CCCC never emerges.
REQ-034 Scenario: random in_valid/out_ready at 50% each over 10,000 cycles -> a scoreboard matches every out_fire to in_fire order with no loss.
REQ-035 Scenario: rst and flush asserted together while holding 16'h1234 -> reset values result and 16'h1234 is never output.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and default constants for the skid-buffered pipeline register.
// The state encoding is fixed at 2 bits so it can be reused by any wrapper logic.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int          DEF_WIDTH     = 16;
  localparam logic [15:0] DEF_RESET_VAL = 16'h0800;

endpackage

// File: rtl/pipe_skid_reg_reg_en_param.sv
// Plain enabled register with a synchronous active-high reset to a parameter value.
// Used for both the main and skid entries of pipe_skid_reg.
module reg_en_param
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: full throughput with in_ready decoded from state only,
// so there is no combinational path from out_ready back to in_ready.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_t           state_p0;
  state_t           state_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             main_sel_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_p0;
  logic [WIDTH-1:0] skid_p0;

  assign in_ready  = (state_p0 != TWO);
  assign out_valid = (state_p0 != EMPTY);
  assign out_data  = out_valid ? main_p0 : RESET_VAL;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and load selection; flush wins over every handshake
  always_comb begin
    state_nxt     = state_p0;
    main_en       = 1'b0;
    main_sel_skid = 1'b0;
    skid_en       = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            main_en   = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            skid_en   = 1'b1;
            state_nxt = TWO;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_en       = 1'b1;
            main_sel_skid = 1'b1;
            state_nxt     = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  assign main_d = main_sel_skid ? skid_p0 : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= EMPTY;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Entry storage: main is the head of the queue, skid catches the overflow entry
  reg_en_param #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_p0)
  );

  reg_en_param #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_p0)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus a randomized scoreboard run for pipe_skid_reg.
module tb_pipe_skid_reg;

  localparam int          W   = 16;
  localparam logic [15:0] NOP = 16'h0800;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         flush;
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         chk;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic [W-1:0] id,
                     input logic ordy, input logic c, input logic eir, input logic eov,
                     input logic [W-1:0] eod);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
    v.chk = c; v.e_ir = eir; v.e_ov = eov; v.e_od = eod;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  logic [W-1:0] sb[$];
  logic         inf, outf;

  initial begin
    // Each row: inputs driven before the next edge; expected outputs reflect state so far.
    //   rst flush iv  id        ordy chk ir ov  od
    add(1, 0, 0, 16'h0000, 0, 0, 1, 0, NOP);     // reset cycle 1
    add(1, 0, 0, 16'h0000, 0, 1, 1, 0, NOP);     // reset cycle 2
    add(0, 0, 1, 16'h1111, 1, 1, 1, 0, NOP);     // reset values after release
    add(0, 0, 1, 16'h2222, 1, 1, 1, 1, 16'h1111);
    add(0, 0, 1, 16'h3333, 1, 1, 1, 1, 16'h2222);
    add(0, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h3333);
    add(0, 0, 1, 16'hAAAA, 0, 1, 1, 0, NOP);     // stall consumer
    add(0, 0, 1, 16'hBBBB, 0, 1, 1, 1, 16'hAAAA);
    add(0, 0, 1, 16'hDEAD, 0, 1, 0, 1, 16'hAAAA); // full: DEAD not accepted
    add(0, 0, 1, 16'hBEEF, 1, 1, 0, 1, 16'hAAAA); // drain AAAA, BEEF not accepted
    add(0, 0, 0, 16'h0000, 1, 1, 1, 1, 16'hBBBB);
    add(0, 0, 0, 16'h0000, 0, 1, 1, 0, NOP);
    add(0, 0, 1, 16'h5555, 0, 1, 1, 0, NOP);     // fill to TWO then flush
    add(0, 0, 1, 16'h6666, 0, 1, 1, 1, 16'h5555);
    add(0, 1, 1, 16'hCCCC, 0, 1, 0, 1, 16'h5555);
    add(0, 0, 0, 16'h0000, 0, 1, 1, 0, NOP);
    add(0, 0, 1, 16'h7777, 0, 1, 1, 0, NOP);     // flush in ONE with same-cycle in_fire
    add(0, 1, 1, 16'hCCCC, 1, 1, 1, 1, 16'h7777);
    add(0, 0, 0, 16'h0000, 1, 1, 1, 0, NOP);
    add(0, 1, 1, 16'hCCCC, 0, 1, 1, 0, NOP);     // flush in EMPTY with in_fire
    add(0, 0, 0, 16'h0000, 0, 1, 1, 0, NOP);
    add(0, 0, 1, 16'h1234, 0, 1, 1, 0, NOP);     // rst + flush together
    add(1, 1, 1, 16'h9999, 1, 1, 1, 1, 16'h1234);
    add(0, 0, 0, 16'h0000, 1, 1, 1, 0, NOP);
    add(0, 0, 1, 16'h4444, 0, 1, 1, 0, NOP);     // rst while full
    add(0, 0, 1, 16'h4545, 0, 1, 1, 1, 16'h4444);
    add(1, 0, 0, 16'h0000, 1, 1, 0, 1, 16'h4444);
    add(0, 0, 0, 16'h0000, 1, 1, 1, 0, NOP);
    add(0, 0, 1, 16'h0101, 1, 1, 1, 0, NOP);     // skid-to-main and simultaneous fire
    add(0, 0, 1, 16'h0202, 0, 1, 1, 1, 16'h0101);
    add(0, 0, 0, 16'h0000, 1, 1, 0, 1, 16'h0101);
    add(0, 0, 1, 16'h0303, 1, 1, 1, 1, 16'h0202);
    add(0, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0303);
    add(0, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h0303);
    add(0, 0, 0, 16'h0000, 0, 1, 1, 0, NOP);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; flush = vq[i].flush; in_valid = vq[i].iv;
      in_data = vq[i].id; out_ready = vq[i].ordy;
      #1;
      if (vq[i].chk) begin
        check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vq[i].e_ir));
        check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vq[i].e_ov));
        check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vq[i].e_od));
      end
    end

    // Random handshakes against a queue model of acceptance order
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      flush = ($urandom_range(0, 63) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_data = W'($urandom);
      out_ready = $urandom_range(0, 1) == 1;
      #1;
      if (in_ready !== (sb.size() < 2)) check("rnd in_ready", 64'(in_ready), 64'(sb.size() < 2));
      if (out_valid !== (sb.size() > 0)) check("rnd out_valid", 64'(out_valid), 64'(sb.size() > 0));
      inf  = in_valid & in_ready;
      outf = out_valid & out_ready;
      if (sb.size() > 0) check("rnd out_data", 64'(out_data), 64'(sb[0]));
      else               check("rnd idle data", 64'(out_data), 64'(NOP));
      if (flush) begin
        sb.delete();
      end else begin
        if (outf && sb.size() > 0) void'(sb.pop_front());
        if (inf) sb.push_back(in_data);
      end
    end

    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
